// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one add/sub/and/xor ALU between two requesters,
// with a single-entry tagged result register. Optional flags: define ALU_CC_EN.
module alu_share_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_val,
  output logic             res_ovf
`ifdef ALU_CC_EN
  ,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic             can_accept, grant0, grant1, xfer;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b, alu_r;
  logic             alu_ovf;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_d    = state_q;
    can_accept = (state_q == EMPTY) || res_ready;
    if (can_accept) begin
      if (req0_valid && req1_valid) begin
        // Tie goes to whichever port did not win last time.
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    xfer = grant0 || grant1;
    unique case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (res_ready && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = (state_q == FULL);

  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;

  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    unique case (sel_op)
      OP_ADD: begin
        alu_r   = sel_a + sel_b;
        alu_ovf = (sel_a[WIDTH-1] == sel_b[WIDTH-1]) && (alu_r[WIDTH-1] != sel_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r   = sel_a + ~sel_b + {{(WIDTH-1){1'b0}}, 1'b1};
        alu_ovf = (sel_a[WIDTH-1] != sel_b[WIDTH-1]) && (alu_r[WIDTH-1] != sel_a[WIDTH-1]);
      end
      OP_AND:  alu_r = sel_a & sel_b;
      OP_XOR:  alu_r = sel_a ^ sel_b;
      default: alu_r = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Result register is reset too: res_* must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_id       <= 1'b0;
      res_val      <= '0;
      res_ovf      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (xfer) begin
      res_id       <= grant1;
      res_val      <= alu_r;
      res_ovf      <= alu_ovf;
      last_grant_q <= grant1;
    end
  end

`ifdef ALU_CC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b0;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (grant0) begin
      cc_zf <= (alu_r == '0);
      cc_sf <= alu_r[WIDTH-1];
      cc_of <= alu_ovf;
    end
  end
`endif

endmodule
